apb_slave_mux_ctrl: RTL and testbench

- Sits between the AHB-to-APB bridge's single APB master port and up to NUM_SLAVES APB peripherals.
- Decodes the transfer address and routes psel to one slave.
- Sequences each transfer through an internal FSM and returns that slave's pready/pslverr/prdata to the bridge.
- Answers unmapped addresses and hung slaves with an error response; keeps sticky status for software and debug.

---
 rtl/apb_slave_mux_ctrl_pkg.sv | 25 ++
 rtl/apb_resp_mux.sv | 39 +++
 rtl/apb_slave_mux_ctrl.sv | 242 ++++++++++++++++++++++++
 tb/tb_apb_slave_mux_ctrl.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_slave_mux_ctrl_pkg.sv
// Shared definitions for the APB slave mux controller.
// Holds the FSM state encoding, response constants and the default address-map
// geometry used as parameter defaults by the top level and the response mux.
package apb_slave_mux_ctrl_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'b00,
    StSetup  = 2'b01,
    StAccess = 2'b10,
    StDone   = 2'b11
  } apb_state_e;

  // pslverr encodings
  localparam logic RespOkay  = 1'b0;
  localparam logic RespError = 1'b1;

  // Default address map: top SEL_BITS of paddr pick one of DefNumSlaves slaves
  localparam int unsigned DefNumSlaves     = 4;
  localparam int unsigned DefPaddrWidth    = 16;
  localparam int unsigned DefDataWidth     = 32;
  localparam int unsigned DefSelBits       = 3;
  localparam int unsigned DefTimeoutCycles = 256;
  localparam int unsigned DefCntWidth      = 8;

endpackage

// File: rtl/apb_resp_mux.sv
// N:1 combinational selection of the APB response of one slave.
// Ports:
//   idx        in   slave index to forward
//   pready_s   in   per-slave pready
//   pslverr_s  in   per-slave pslverr
//   prdata_s   in   per-slave read data, slave i at [i*W +: W]
//   pready     out  pready of slave idx (0 if idx is out of range)
//   pslverr    out  pslverr of slave idx (OKAY if out of range)
//   prdata     out  prdata of slave idx (0 if out of range)
module apb_resp_mux
  import apb_slave_mux_ctrl_pkg::*;
#(
  parameter int unsigned NUM_SLAVES     = DefNumSlaves,
  parameter int unsigned APB_DATA_WIDTH = DefDataWidth,
  parameter int unsigned SEL_BITS       = DefSelBits
) (
  input  logic [SEL_BITS-1:0]                  idx,
  input  logic [NUM_SLAVES-1:0]                pready_s,
  input  logic [NUM_SLAVES-1:0]                pslverr_s,
  input  logic [NUM_SLAVES*APB_DATA_WIDTH-1:0] prdata_s,
  output logic                                 pready,
  output logic                                 pslverr,
  output logic [APB_DATA_WIDTH-1:0]            prdata
);

  always_comb begin
    pready  = 1'b0;
    pslverr = RespOkay;
    prdata  = '0;
    for (int i = 0; i < int'(NUM_SLAVES); i++) begin
      if (int'(idx) == i) begin
        pready  = pready_s[i];
        pslverr = pslverr_s[i];
        prdata  = prdata_s[i*APB_DATA_WIDTH +: APB_DATA_WIDTH];
      end
    end
  end

endmodule

// File: rtl/apb_slave_mux_ctrl.sv
// APB slave mux controller: routes the bridge's single APB master port to one of
// NUM_SLAVES peripherals, sequences the transfer, answers unmapped addresses and
// hung slaves with an error, and keeps sticky error status.
// Ports:
//   hclk, hreset                  clock, synchronous active-high reset
//   psel_en, penable, paddr       bridge request
//   pready_x, pslverr_x, prdata_x response returned to the bridge
//   psel_s                        one-hot slave selects
//   pready_s, pslverr_s, prdata_s per-slave responses
//   clr_status                    clears timeout_flag, err_cnt, last_err_idx
//   timeout_flag                  sticky timeout indication
//   err_cnt                       saturating count of error responses
//   last_err_idx                  slave index of the most recent error response
module apb_slave_mux_ctrl
  import apb_slave_mux_ctrl_pkg::*;
#(
  parameter int unsigned NUM_SLAVES     = DefNumSlaves,
  parameter int unsigned PADDR_WIDTH    = DefPaddrWidth,
  parameter int unsigned APB_DATA_WIDTH = DefDataWidth,
  parameter int unsigned SEL_BITS       = DefSelBits,
  parameter int unsigned TIMEOUT_CYCLES = DefTimeoutCycles,
  parameter int unsigned CNT_WIDTH      = DefCntWidth
) (
  input  logic                                 hclk,
  input  logic                                 hreset,
  input  logic                                 psel_en,
  input  logic                                 penable,
  input  logic [PADDR_WIDTH-1:0]               paddr,
  output logic                                 pready_x,
  output logic                                 pslverr_x,
  output logic [APB_DATA_WIDTH-1:0]            prdata_x,
  output logic [NUM_SLAVES-1:0]                psel_s,
  input  logic [NUM_SLAVES-1:0]                pready_s,
  input  logic [NUM_SLAVES-1:0]                pslverr_s,
  input  logic [NUM_SLAVES*APB_DATA_WIDTH-1:0] prdata_s,
  input  logic                                 clr_status,
  output logic                                 timeout_flag,
  output logic [CNT_WIDTH-1:0]                 err_cnt,
  output logic [SEL_BITS-1:0]                  last_err_idx
);

  localparam logic [CNT_WIDTH-1:0] TimerLast = CNT_WIDTH'(TIMEOUT_CYCLES - 1);

  apb_state_e state_q, state_d;

  logic [SEL_BITS-1:0]  idx_q, idx_d;
  logic                 mapped_q, mapped_d;
  logic [CNT_WIDTH-1:0] timer_q, timer_d;
  logic                 timeout_flag_q, timeout_flag_d;
  logic [CNT_WIDTH-1:0] err_cnt_q, err_cnt_d;
  logic [SEL_BITS-1:0]  last_err_idx_q, last_err_idx_d;

  // Address decode on the live bus
  logic [SEL_BITS-1:0] dec_idx;
  logic                dec_mapped;
  logic                unused_paddr_lsb;

  assign dec_idx          = paddr[PADDR_WIDTH-1 -: SEL_BITS];
  assign dec_mapped       = int'(dec_idx) < int'(NUM_SLAVES);
  assign unused_paddr_lsb = ^paddr[PADDR_WIDTH-SEL_BITS-1:0];

  // Selected slave response, always indexed by the latched index
  logic                      mux_pready;
  logic                      mux_pslverr;
  logic [APB_DATA_WIDTH-1:0] mux_prdata;

  apb_resp_mux #(
    .NUM_SLAVES     (NUM_SLAVES),
    .APB_DATA_WIDTH (APB_DATA_WIDTH),
    .SEL_BITS       (SEL_BITS)
  ) u_resp_mux (
    .idx       (idx_q),
    .pready_s  (pready_s),
    .pslverr_s (pslverr_s),
    .prdata_s  (prdata_s),
    .pready    (mux_pready),
    .pslverr   (mux_pslverr),
    .prdata    (mux_prdata)
  );

  logic timeout_hit;
  logic resp_cycle;

  ///////////////////
  // State register //
  ///////////////////

  always_ff @(posedge hclk) begin
    if (hreset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  ////////////////
  // Next state //
  ////////////////

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        // penable may arrive together with psel: skip straight to ACCESS
        if (psel_en) state_d = penable ? StAccess : StSetup;
      end
      StSetup: begin
        if (!psel_en)     state_d = StIdle;
        else if (penable) state_d = StAccess;
      end
      StAccess: begin
        if (resp_cycle) state_d = StDone;
      end
      StDone: begin
        // Wait for the bridge to drop psel so the finished transfer is not re-latched
        if (!psel_en) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  /////////////
  // Outputs //
  /////////////

  always_comb begin
    psel_s      = '0;
    pready_x    = 1'b0;
    pslverr_x   = RespOkay;
    prdata_x    = '0;
    timeout_hit = 1'b0;

    // Reset kills selects and responses in the same cycle
    if (!hreset) begin
      unique case (state_q)
        StIdle: begin
          if (psel_en && dec_mapped) begin
            for (int i = 0; i < int'(NUM_SLAVES); i++) begin
              psel_s[i] = (int'(dec_idx) == i);
            end
          end
        end
        StSetup: begin
          if (psel_en && mapped_q) begin
            for (int i = 0; i < int'(NUM_SLAVES); i++) begin
              psel_s[i] = (int'(idx_q) == i);
            end
          end
        end
        StAccess: begin
          if (psel_en && mapped_q) begin
            for (int i = 0; i < int'(NUM_SLAVES); i++) begin
              psel_s[i] = (int'(idx_q) == i);
            end
          end
          if (!mapped_q) begin
            // Zero-wait-state error for unmapped addresses
            pready_x  = 1'b1;
            pslverr_x = RespError;
          end else if (mux_pready) begin
            // Slave ready wins over a coincident timeout
            pready_x  = 1'b1;
            pslverr_x = mux_pslverr;
            prdata_x  = mux_prdata;
          end else if (timer_q == TimerLast) begin
            timeout_hit = 1'b1;
            pready_x    = 1'b1;
            pslverr_x   = RespError;
          end else begin
            pslverr_x = mux_pslverr;
            prdata_x  = mux_prdata;
          end
        end
        StDone: ;
        default: ;
      endcase
    end
  end

  assign resp_cycle = (state_q == StAccess) && pready_x;

  //////////////
  // Datapath //
  //////////////

  always_comb begin
    idx_d    = idx_q;
    mapped_d = mapped_q;
    if (state_q == StIdle && psel_en) begin
      idx_d    = dec_idx;
      mapped_d = dec_mapped;
    end
  end

  always_comb begin
    timer_d = '0;
    if (state_q == StAccess && !pready_x) timer_d = timer_q + 1'b1;
  end

  always_comb begin
    timeout_flag_d = timeout_flag_q;
    err_cnt_d      = err_cnt_q;
    last_err_idx_d = last_err_idx_q;

    if (timeout_hit) timeout_flag_d = 1'b1;

    if (resp_cycle && pslverr_x == RespError) begin
      if (err_cnt_q != '1) err_cnt_d = err_cnt_q + 1'b1;
      last_err_idx_d = idx_q;
    end

    // Software clear takes priority over any same-cycle update
    if (clr_status) begin
      timeout_flag_d = 1'b0;
      err_cnt_d      = '0;
      last_err_idx_d = '0;
    end
  end

  always_ff @(posedge hclk) begin
    if (hreset) begin
      idx_q          <= '0;
      mapped_q       <= 1'b0;
      timer_q        <= '0;
      timeout_flag_q <= 1'b0;
      err_cnt_q      <= '0;
      last_err_idx_q <= '0;
    end else begin
      idx_q          <= idx_d;
      mapped_q       <= mapped_d;
      timer_q        <= timer_d;
      timeout_flag_q <= timeout_flag_d;
      err_cnt_q      <= err_cnt_d;
      last_err_idx_q <= last_err_idx_d;
    end
  end

  assign timeout_flag = timeout_flag_q;
  assign err_cnt      = err_cnt_q;
  assign last_err_idx = last_err_idx_q;

endmodule

// File: tb/tb_apb_slave_mux_ctrl.sv
// Directed self-checking bench for apb_slave_mux_ctrl (4 slaves, timeout 8 cycles).
module tb_apb_slave_mux_ctrl;

  localparam int NS = 4;
  localparam int DW = 32;

  logic             hclk = 1'b0;
  logic             hreset;
  logic             psel_en;
  logic             penable;
  logic [15:0]      paddr;
  logic             pready_x;
  logic             pslverr_x;
  logic [DW-1:0]    prdata_x;
  logic [NS-1:0]    psel_s;
  logic [NS-1:0]    pready_s;
  logic [NS-1:0]    pslverr_s;
  logic [NS*DW-1:0] prdata_s;
  logic             clr_status;
  logic             timeout_flag;
  logic [7:0]       err_cnt;
  logic [2:0]       last_err_idx;

  int n_vec = 0;
  int n_err = 0;

  int rise0 = 0;
  int rise2 = 0;
  logic [NS-1:0] psel_prev = '0;

  apb_slave_mux_ctrl #(
    .NUM_SLAVES     (4),
    .PADDR_WIDTH    (16),
    .APB_DATA_WIDTH (32),
    .SEL_BITS       (3),
    .TIMEOUT_CYCLES (8),
    .CNT_WIDTH      (8)
  ) dut (
    .hclk         (hclk),
    .hreset       (hreset),
    .psel_en      (psel_en),
    .penable      (penable),
    .paddr        (paddr),
    .pready_x     (pready_x),
    .pslverr_x    (pslverr_x),
    .prdata_x     (prdata_x),
    .psel_s       (psel_s),
    .pready_s     (pready_s),
    .pslverr_s    (pslverr_s),
    .prdata_s     (prdata_s),
    .clr_status   (clr_status),
    .timeout_flag (timeout_flag),
    .err_cnt      (err_cnt),
    .last_err_idx (last_err_idx)
  );

  always #5 hclk = ~hclk;

  // Count rising edges of the slave selects, sampled away from the active edge
  always @(negedge hclk) begin
    if (psel_s[0] && !psel_prev[0]) rise0 <= rise0 + 1;
    if (psel_s[2] && !psel_prev[2]) rise2 <= rise2 + 1;
    psel_prev <= psel_s;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge
  task automatic tick();
    @(posedge hclk);
    #2;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic unmapped_xfer();
    psel_en = 1'b1;
    penable = 1'b1;
    paddr   = 16'hA000;
    tick();
    tick();
    psel_en = 1'b0;
    penable = 1'b0;
    tick();
  endtask

  initial begin
    int r0;
    int r2;
    hreset     = 1'b1;
    psel_en    = 1'b1;
    penable    = 1'b0;
    paddr      = 16'h2010;
    pready_s   = '0;
    pslverr_s  = '0;
    prdata_s   = {32'hDDDD0003, 32'hCCCC0002, 32'hCAFE0001, 32'hAAAA0000};
    clr_status = 1'b0;

    // Reset state
    tick();
    tick();
    settle();
    check_eq("rst_psel_s", 32'(psel_s), 32'h0);
    check_eq("rst_pready_x", 32'(pready_x), 32'h0);
    check_eq("rst_prdata_x", prdata_x, 32'h0);
    check_eq("rst_err_cnt", 32'(err_cnt), 32'h0);
    check_eq("rst_timeout_flag", 32'(timeout_flag), 32'h0);
    check_eq("rst_last_err_idx", 32'(last_err_idx), 32'h0);
    psel_en = 1'b0;
    hreset  = 1'b0;
    tick();

    // 1: read from slave 1, zero wait states
    psel_en  = 1'b1;
    penable  = 1'b0;
    paddr    = 16'h2010;
    pready_s = 4'b0010;
    settle();
    check_eq("t1_idle_psel", 32'(psel_s), 32'h2);
    tick();
    penable = 1'b1;
    settle();
    check_eq("t1_setup_psel", 32'(psel_s), 32'h2);
    check_eq("t1_setup_pready", 32'(pready_x), 32'h0);
    tick();
    settle();
    check_eq("t1_acc_pready", 32'(pready_x), 32'h1);
    check_eq("t1_acc_prdata", prdata_x, 32'hCAFE0001);
    check_eq("t1_acc_pslverr", 32'(pslverr_x), 32'h0);
    tick();
    settle();
    check_eq("t1_done_psel", 32'(psel_s), 32'h0);
    check_eq("t1_done_pready", 32'(pready_x), 32'h0);
    psel_en  = 1'b0;
    penable  = 1'b0;
    pready_s = '0;
    tick();
    settle();
    check_eq("t1_err_cnt", 32'(err_cnt), 32'h0);

    // 2: slave 3, five wait states then an error response
    psel_en = 1'b1;
    paddr   = 16'h6000;
    settle();
    check_eq("t2_idle_psel", 32'(psel_s), 32'h8);
    tick();
    penable = 1'b1;
    tick();
    for (int k = 0; k < 5; k++) begin
      settle();
      check_eq($sformatf("t2_wait%0d_pready", k), 32'(pready_x), 32'h0);
      tick();
    end
    pready_s  = 4'b1000;
    pslverr_s = 4'b1000;
    settle();
    check_eq("t2_resp_pready", 32'(pready_x), 32'h1);
    check_eq("t2_resp_pslverr", 32'(pslverr_x), 32'h1);
    tick();
    settle();
    check_eq("t2_err_cnt", 32'(err_cnt), 32'h1);
    check_eq("t2_last_err_idx", 32'(last_err_idx), 32'h3);
    check_eq("t2_done_psel", 32'(psel_s), 32'h0);
    psel_en   = 1'b0;
    penable   = 1'b0;
    pready_s  = '0;
    pslverr_s = '0;
    tick();

    // 3: unmapped address, psel and penable raised together
    psel_en  = 1'b1;
    penable  = 1'b1;
    paddr    = 16'hA000;
    settle();
    check_eq("t3_idle_psel", 32'(psel_s), 32'h0);
    tick();
    settle();
    check_eq("t3_acc_psel", 32'(psel_s), 32'h0);
    check_eq("t3_acc_pready", 32'(pready_x), 32'h1);
    check_eq("t3_acc_pslverr", 32'(pslverr_x), 32'h1);
    check_eq("t3_acc_prdata", prdata_x, 32'h0);
    tick();
    settle();
    check_eq("t3_err_cnt", 32'(err_cnt), 32'h2);
    check_eq("t3_last_err_idx", 32'(last_err_idx), 32'h5);
    psel_en = 1'b0;
    penable = 1'b0;
    tick();

    // 4: slave 0 never ready -> timeout on the 8th access cycle
    psel_en = 1'b1;
    paddr   = 16'h0000;
    tick();
    penable = 1'b1;
    tick();
    for (int k = 1; k < 8; k++) begin
      settle();
      check_eq($sformatf("t4_wait%0d_pready", k), 32'(pready_x), 32'h0);
      tick();
    end
    settle();
    check_eq("t4_to_pready", 32'(pready_x), 32'h1);
    check_eq("t4_to_pslverr", 32'(pslverr_x), 32'h1);
    check_eq("t4_to_prdata", prdata_x, 32'h0);
    check_eq("t4_to_flag_before", 32'(timeout_flag), 32'h0);
    tick();
    settle();
    check_eq("t4_flag_after", 32'(timeout_flag), 32'h1);
    check_eq("t4_done_psel", 32'(psel_s), 32'h0);
    check_eq("t4_err_cnt", 32'(err_cnt), 32'h3);
    check_eq("t4_last_err_idx", 32'(last_err_idx), 32'h0);
    psel_en = 1'b0;
    penable = 1'b0;
    tick();

    // 5: back-to-back transfers to slaves 2 and 0, psel held in DONE
    r0       = rise0;
    r2       = rise2;
    pready_s = '1;
    for (int t = 0; t < 2; t++) begin
      psel_en = 1'b1;
      penable = 1'b0;
      paddr   = (t == 0) ? 16'h4000 : 16'h0000;
      tick();
      penable = 1'b1;
      tick();
      settle();
      check_eq($sformatf("t5_x%0d_pready", t), 32'(pready_x), 32'h1);
      check_eq($sformatf("t5_x%0d_prdata", t), prdata_x,
               (t == 0) ? 32'hCCCC0002 : 32'hAAAA0000);
      tick();
      settle();
      check_eq($sformatf("t5_x%0d_done0_psel", t), 32'(psel_s), 32'h0);
      tick();
      settle();
      check_eq($sformatf("t5_x%0d_done1_psel", t), 32'(psel_s), 32'h0);
      psel_en = 1'b0;
      penable = 1'b0;
      tick();
    end
    pready_s = '0;
    tick();
    check_eq("t5_sel2_count", 32'(rise2 - r2), 32'h1);
    check_eq("t5_sel0_count", 32'(rise0 - r0), 32'h1);
    check_eq("t5_err_cnt", 32'(err_cnt), 32'h3);

    // 6: saturation of err_cnt, clear priority, reset mid-access
    for (int k = 0; k < 252; k++) unmapped_xfer();
    settle();
    check_eq("t6_err_cnt_255", 32'(err_cnt), 32'hFF);
    unmapped_xfer();
    settle();
    check_eq("t6_err_cnt_sat", 32'(err_cnt), 32'hFF);

    psel_en = 1'b1;
    penable = 1'b1;
    paddr   = 16'hA000;
    tick();
    clr_status = 1'b1;
    settle();
    check_eq("t6_clr_resp_pslverr", 32'(pslverr_x), 32'h1);
    tick();
    clr_status = 1'b0;
    settle();
    check_eq("t6_clr_err_cnt", 32'(err_cnt), 32'h0);
    check_eq("t6_clr_last_err_idx", 32'(last_err_idx), 32'h0);
    check_eq("t6_clr_timeout_flag", 32'(timeout_flag), 32'h0);
    psel_en = 1'b0;
    penable = 1'b0;
    tick();

    psel_en = 1'b1;
    penable = 1'b1;
    paddr   = 16'h2010;
    tick();
    settle();
    check_eq("t6_acc_psel", 32'(psel_s), 32'h2);
    hreset   = 1'b1;
    pready_s = 4'b0010;
    settle();
    check_eq("t6_rst_psel", 32'(psel_s), 32'h0);
    check_eq("t6_rst_pready", 32'(pready_x), 32'h0);
    tick();
    hreset   = 1'b0;
    penable  = 1'b0;
    pready_s = '0;
    paddr    = 16'h0000;
    settle();
    // Only IDLE decodes the live address, so slave 0 selected here means IDLE
    check_eq("t6_after_rst_idle_psel", 32'(psel_s), 32'h1);
    check_eq("t6_after_rst_err_cnt", 32'(err_cnt), 32'h0);
    psel_en = 1'b0;
    tick();
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
